// File: rtl/life_controller.sv
// life_controller: paces Life generations for the solver and serialises cell edits on arena port B.
// Define LIFE_CTRL_OVERRUN_EN to add the saturating overrun_count output for dropped generation requests.
module life_controller #(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10,
  parameter int TICK_DIV     = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   edit_req,
  input  logic [9:0]             edit_row,
  input  logic [9:0]             edit_col,
  input  logic [1:0]             edit_op,
  output logic                   edit_ack,
  output logic                   busy,
  output logic [31:0]            generation,
  output logic                   solver_start,
  output logic [31:0]            solver_generations,
  input  logic                   solver_ready,
  input  logic [9:0]             solver_row_select,
  input  logic [ARENA_WIDTH-1:0] solver_columns_new,
  input  logic                   solver_write,
  output logic [ARENA_WIDTH-1:0] solver_columns,
  output logic [9:0]             arena_row,
  input  logic [ARENA_WIDTH-1:0] arena_columns_in,
  output logic [ARENA_WIDTH-1:0] arena_columns_out,
  output logic                   arena_write
`ifdef LIFE_CTRL_OVERRUN_EN
  ,
  output logic [15:0]            overrun_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, START, SOLVE_ACK, SOLVE_RUN, EDIT_RD, EDIT_MOD, EDIT_WR
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_SET    = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_NOP    = 2'b11
  } edit_op_t;

  localparam int                     PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]          TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]             ROW_LIMIT = 10'(ARENA_HEIGHT);
  localparam logic [9:0]             COL_LIMIT = 10'(ARENA_WIDTH);
  localparam logic [ARENA_WIDTH-1:0] BIT0      = {{(ARENA_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PW-1:0]          prescaler;
  logic                   pending;
  logic                   tick;
  logic                   take_pending;
  logic                   solver_owns;
  logic [9:0]             row_q;
  logic [9:0]             col_q;
  edit_op_t               op_q;
  logic                   wr_en_q;
  logic [ARENA_WIDTH-1:0] word_q;
  logic [ARENA_WIDTH-1:0] word_mod;
  logic [ARENA_WIDTH-1:0] bit_mask;

  assign tick         = run && (prescaler == TICK_LAST);
  assign take_pending = (state_q == IDLE) && !edit_req && pending;
  assign solver_owns  = (state_q == START) || (state_q == SOLVE_ACK) || (state_q == SOLVE_RUN);

  // A request arriving while one generation is already queued is dropped, not stacked.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      prescaler  <= '0;
      pending    <= 1'b0;
      generation <= '0;
      row_q      <= '0;
      col_q      <= '0;
      op_q       <= OP_NOP;
      wr_en_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!run || tick) prescaler <= '0;
      else              prescaler <= prescaler + 1'b1;
      if (pending) begin
        if (take_pending) pending <= 1'b0;
      end else if (tick || step) begin
        pending <= 1'b1;
      end
      if (state_q == SOLVE_RUN && solver_ready) generation <= generation + 32'd1;
      if (state_q == IDLE && edit_req) begin
        row_q   <= edit_row;
        col_q   <= edit_col;
        op_q    <= edit_op_t'(edit_op);
        wr_en_q <= (edit_row < ROW_LIMIT) && (edit_col < COL_LIMIT)
                   && (edit_op_t'(edit_op) != OP_NOP);
      end
      if (state_q == EDIT_MOD) word_q <= word_mod;
    end
  end

`ifdef LIFE_CTRL_OVERRUN_EN
  logic [1:0]  drops;
  logic [16:0] overrun_sum;

  assign drops       = {1'b0, tick && pending} + {1'b0, step && pending};
  assign overrun_sum = {1'b0, overrun_count} + {15'b0, drops};

  always_ff @(posedge clk) begin
    if (reset)               overrun_count <= '0;
    else if (overrun_sum[16]) overrun_count <= 16'hFFFF;
    else                     overrun_count <= overrun_sum[15:0];
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (edit_req)     state_d = EDIT_RD;
        else if (pending) state_d = START;
      end
      START:     state_d = SOLVE_ACK;
      SOLVE_ACK: if (!solver_ready) state_d = SOLVE_RUN;
      SOLVE_RUN: if (solver_ready)  state_d = IDLE;
      EDIT_RD:   state_d = EDIT_MOD;
      EDIT_MOD:  state_d = EDIT_WR;
      EDIT_WR:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Out-of-range columns shift the mask to zero; those edits never write anyway.
  always_comb begin
    bit_mask = BIT0 << col_q;
    word_mod = arena_columns_in;
    case (op_q)
      OP_CLEAR:  word_mod = arena_columns_in & ~bit_mask;
      OP_SET:    word_mod = arena_columns_in | bit_mask;
      OP_TOGGLE: word_mod = arena_columns_in ^ bit_mask;
      default:   word_mod = arena_columns_in;
    endcase
  end

  always_comb begin
    solver_start       = (state_q == START);
    edit_ack           = (state_q == EDIT_WR);
    busy               = (state_q != IDLE);
    solver_generations = 32'd1;
    solver_columns     = arena_columns_in;
    arena_row          = row_q;
    arena_columns_out  = word_q;
    arena_write        = (state_q == EDIT_WR) && wr_en_q;
    if (solver_owns) begin
      arena_row         = solver_row_select;
      arena_columns_out = solver_columns_new;
      arena_write       = solver_write;
    end
  end

endmodule

// File: tb/tb_life_controller.sv
// Self-checking bench for life_controller: arena and solver models plus a scoreboard of expected
// solver_start and edit_ack cycles; checks overrun_count too when LIFE_CTRL_OVERRUN_EN is defined.
module tb_life_controller;
  localparam int W         = 10;
  localparam int H         = 10;
  localparam int TD        = 8;
  localparam int SOLVE_LEN = 5;

  logic          clk = 1'b0;
  logic          reset, run, step, edit_req;
  logic [9:0]    edit_row, edit_col;
  logic [1:0]    edit_op;
  logic          edit_ack, busy;
  logic [31:0]   generation;
  logic          solver_start;
  logic [31:0]   solver_generations;
  logic          solver_ready;
  logic [9:0]    solver_row_select;
  logic [W-1:0]  solver_columns_new;
  logic          solver_write;
  logic [W-1:0]  solver_columns;
  logic [9:0]    arena_row;
  logic [W-1:0]  arena_columns_in, arena_columns_out;
  logic          arena_write;
`ifdef LIFE_CTRL_OVERRUN_EN
  logic [15:0]   overrun_count;
`endif

  always #5 clk = ~clk;

  life_controller #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .edit_req(edit_req), .edit_row(edit_row), .edit_col(edit_col), .edit_op(edit_op),
    .edit_ack(edit_ack), .busy(busy), .generation(generation),
    .solver_start(solver_start), .solver_generations(solver_generations),
    .solver_ready(solver_ready), .solver_row_select(solver_row_select),
    .solver_columns_new(solver_columns_new), .solver_write(solver_write),
    .solver_columns(solver_columns), .arena_row(arena_row),
    .arena_columns_in(arena_columns_in), .arena_columns_out(arena_columns_out),
    .arena_write(arena_write)
`ifdef LIFE_CTRL_OVERRUN_EN
    , .overrun_count(overrun_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Arena port B: registered read, write at the edge; deep enough that stray rows land somewhere visible.
  logic [W-1:0] arena [1024];
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 1024; r++) arena[r] <= '0;
      arena_columns_in <= '0;
    end else begin
      arena_columns_in <= arena[arena_row];
      if (arena_write) arena[arena_row] <= arena_columns_out;
    end
  end

  // Solver: drops ready the edge after start, holds it low SOLVE_LEN cycles, writes row 7 once.
  logic [3:0] solve_cnt;
  always @(posedge clk) begin
    if (reset) begin
      solver_ready <= 1'b1;
      solve_cnt    <= '0;
    end else if (solver_start) begin
      solver_ready <= 1'b0;
      solve_cnt    <= 4'(SOLVE_LEN - 1);
    end else if (solve_cnt != 0) begin
      solve_cnt <= solve_cnt - 4'd1;
    end else begin
      solver_ready <= 1'b1;
    end
  end
  assign solver_write       = !solver_ready && (solve_cnt == 4'd1);
  assign solver_row_select  = 10'd7;
  assign solver_columns_new = 10'h155;

  typedef struct packed {
    int         cyc;
    logic       wr;
    logic [9:0] row;
    logic [W-1:0] data;
  } ack_exp_t;

  int       start_q[$];
  ack_exp_t ack_q[$];
  logic [W-1:0] exp_arena [1024];
  int       n_checks = 0;
  int       n_errors = 0;
  int       wr_count = 0;
  int       exp_gen  = 0;
  int       mon_start;
  ack_exp_t mon_ack;

  task automatic clear_model();
    for (int r = 0; r < 1024; r++) exp_arena[r] = '0;
  endtask

  task automatic push_edit(input int at, input logic [9:0] row, input logic [9:0] col,
                           input logic [1:0] op);
    ack_exp_t e;
    e.cyc  = at;
    e.row  = row;
    e.wr   = (row < 10'(H)) && (col < 10'(W)) && (op != 2'b11);
    e.data = '0;
    if (e.wr) begin
      e.data = exp_arena[row];
      case (op)
        2'b00:   e.data[col[3:0]] = 1'b0;
        2'b01:   e.data[col[3:0]] = 1'b1;
        default: e.data[col[3:0]] = ~e.data[col[3:0]];
      endcase
      exp_arena[row] = e.data;
    end
    ack_q.push_back(e);
  endtask

  // Pops the scoreboard whenever the DUT pulses solver_start or edit_ack.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (arena_write === 1'b1) wr_count++;
      if (reset === 1'b0 && solver_start === 1'b1) begin
        n_checks++;
        if (start_q.size() == 0) begin
          n_errors++;
          $display("FAIL start_unexpected: solver_start high at cycle %0d, none expected", cyc);
        end else begin
          mon_start = start_q.pop_front();
          if (cyc != mon_start) begin
            n_errors++;
            $display("FAIL start_cycle: solver_start at cycle %0d, expected %0d", cyc, mon_start);
          end
        end
      end
      if (reset === 1'b0 && edit_ack === 1'b1) begin
        n_checks++;
        if (ack_q.size() == 0) begin
          n_errors++;
          $display("FAIL ack_unexpected: edit_ack high at cycle %0d, none expected", cyc);
        end else begin
          mon_ack = ack_q.pop_front();
          if (cyc != mon_ack.cyc) begin
            n_errors++;
            $display("FAIL ack_cycle: edit_ack at cycle %0d, expected %0d", cyc, mon_ack.cyc);
          end
          n_checks++;
          if (arena_write !== mon_ack.wr) begin
            n_errors++;
            $display("FAIL ack_write: arena_write=%b at ack, expected %b", arena_write, mon_ack.wr);
          end
          if (mon_ack.wr) begin
            n_checks++;
            if (arena_row !== mon_ack.row || arena_columns_out !== mon_ack.data) begin
              n_errors++;
              $display("FAIL ack_data: row %0d data %b, expected row %0d data %b",
                       arena_row, arena_columns_out, mon_ack.row, mon_ack.data);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i;
    i = 0;
    while ((start_q.size() != 0 || ack_q.size() != 0) && i < bound) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (start_q.size() != 0 || ack_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d starts and %0d acks outstanding, expected 0",
               name, start_q.size(), ack_q.size());
      start_q.delete();
      ack_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle: busy=%b, expected 0", name, busy);
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && solver_start !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic run_edit(input logic [9:0] row, input logic [9:0] col, input logic [1:0] op);
    @(negedge clk);
    edit_req = 1'b1;
    edit_row = row;
    edit_col = col;
    edit_op  = op;
    push_edit(cyc + 3, row, col, op);
    for (int i = 0; i < 10 && edit_ack !== 1'b1; i++) @(negedge clk);
    edit_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({busy, solver_start, edit_ack, arena_write} !== 4'b0 || generation !== 32'd0) begin
      n_errors++;
      $display("FAIL %s_ctrl: busy=%b start=%b ack=%b write=%b gen=%0d, expected all 0",
               name, busy, solver_start, edit_ack, arena_write, generation);
    end
    n_checks++;
    if (arena_row !== 10'd0 || arena_columns_out !== '0 || solver_generations !== 32'd1) begin
      n_errors++;
      $display("FAIL %s_port: row=%0d out=%h solver_generations=%0d, expected 0 0 1",
               name, arena_row, arena_columns_out, solver_generations);
    end
`ifdef LIFE_CTRL_OVERRUN_EN
    n_checks++;
    if (overrun_count !== 16'd0) begin
      n_errors++;
      $display("FAIL %s_overrun: overrun_count=%0d, expected 0", name, overrun_count);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; step = 1'b1; run = 1'b1; edit_req = 1'b1; edit_row = 10'd3; edit_op = 2'b01;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0; step = 1'b0; run = 1'b0; edit_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_leak: busy=%b after release, expected 0", busy);
    end
  endtask

  task automatic test_step();
    @(negedge clk);
    step = 1'b1;
    start_q.push_back(cyc + 2);
    exp_gen++;
    @(negedge clk);
    step = 1'b0;
    wait_drain(20, "step");
    wait_idle("step");
    n_checks++;
    if (generation !== 32'(exp_gen)) begin
      n_errors++;
      $display("FAIL step_generation: generation=%0d, expected %0d", generation, exp_gen);
    end
    n_checks++;
    if (arena[7] !== 10'h155) begin
      n_errors++;
      $display("FAIL step_solver_write: arena row 7=%h, expected 155", arena[7]);
    end
  endtask

  task automatic test_edit();
    @(negedge clk);
    edit_req = 1'b1; edit_row = 10'd3; edit_col = 10'd4; edit_op = 2'b01;
    push_edit(cyc + 3, 10'd3, 10'd4, 2'b01);
    @(negedge clk);
    edit_row = 10'd5; edit_col = 10'd0; edit_op = 2'b00;
    for (int i = 0; i < 10 && edit_ack !== 1'b1; i++) @(negedge clk);
    edit_req = 1'b0;
    @(negedge clk);
    wait_drain(5, "edit");
    n_checks++;
    if (arena[3] !== 10'b0000010000 || arena[5] !== 10'd0) begin
      n_errors++;
      $display("FAIL edit_set: rows 3/5 = %b/%b, expected 0000010000/0000000000", arena[3], arena[5]);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    @(negedge clk);
    edit_req = 1'b1; edit_row = 10'd9; edit_col = 10'd9; edit_op = 2'b01;
    push_edit(cyc + 3, 10'd9, 10'd9, 2'b01);
    for (int i = 0; i < 10 && edit_ack !== 1'b1; i++) @(negedge clk);
    a = cyc;
    edit_row = 10'd3; edit_col = 10'd4; edit_op = 2'b10;
    push_edit(a + 4, 10'd3, 10'd4, 2'b10);
    @(negedge clk);
    for (int i = 0; i < 10 && edit_ack !== 1'b1; i++) @(negedge clk);
    edit_req = 1'b0;
    repeat (8) @(negedge clk);
    wait_drain(1, "b2b");
    n_checks++;
    if (arena[3] !== 10'd0 || arena[9] !== 10'h200) begin
      n_errors++;
      $display("FAIL b2b_arena: rows 3/9 = %h/%h, expected 000/200", arena[3], arena[9]);
    end
  endtask

  task automatic test_out_of_range();
    int w0;
    w0 = wr_count;
    run_edit(10'd12, 10'd4, 2'b01);
    run_edit(10'd2, 10'd10, 2'b01);
    run_edit(10'd2, 10'd4, 2'b11);
    wait_drain(5, "oor");
    n_checks++;
    if (wr_count != w0 || arena[12] !== 10'd0 || arena[2] !== 10'd0) begin
      n_errors++;
      $display("FAIL oor_write: %0d writes, rows 12/2 = %h/%h, expected 0 writes and 000/000",
               wr_count - w0, arena[12], arena[2]);
    end
  endtask

  task automatic test_edit_vs_step();
    @(negedge clk);
    edit_req = 1'b1; edit_row = 10'd1; edit_col = 10'd0; edit_op = 2'b01; step = 1'b1;
    push_edit(cyc + 3, 10'd1, 10'd0, 2'b01);
    start_q.push_back(cyc + 5);
    exp_gen++;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 10 && edit_ack !== 1'b1; i++) @(negedge clk);
    edit_req = 1'b0;
    wait_drain(20, "arb");
    wait_idle("arb");
    n_checks++;
    if (generation !== 32'(exp_gen) || arena[1] !== 10'd1) begin
      n_errors++;
      $display("FAIL arb_result: generation=%0d row1=%h, expected %0d and 001",
               generation, arena[1], exp_gen);
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    step = 1'b1;
    start_q.push_back(cyc + 2);
    exp_gen++;
    @(negedge clk);
    step = 1'b0;
    wait_start();
    start_q.push_back(cyc + 8);
    exp_gen++;
    repeat (3) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
    wait_drain(20, "drop");
    wait_idle("drop");
    repeat (10) @(negedge clk);
    n_checks++;
    if (generation !== 32'(exp_gen) || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_generation: generation=%0d busy=%b, expected %0d and 0",
               generation, busy, exp_gen);
    end
`ifdef LIFE_CTRL_OVERRUN_EN
    n_checks++;
    if (overrun_count !== 16'd2) begin
      n_errors++;
      $display("FAIL drop_overrun: overrun_count=%0d, expected 2", overrun_count);
    end
`endif
  endtask

  task automatic test_run();
    int c;
    @(negedge clk);
    c   = cyc;
    run = 1'b1;
    for (int k = 0; k < 4; k++) start_q.push_back(c + TD + 1 + TD * k);
    exp_gen += 4;
    wait_drain(60, "run");
    run = 1'b0;
    wait_idle("run");
    repeat (12) @(negedge clk);
    n_checks++;
    if (generation !== 32'(exp_gen)) begin
      n_errors++;
      $display("FAIL run_generation: generation=%0d, expected %0d", generation, exp_gen);
    end
  endtask

  task automatic test_reset_mid_solve();
    @(negedge clk);
    step = 1'b1;
    start_q.push_back(cyc + 2);
    @(negedge clk);
    step = 1'b0;
    wait_start();
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("solve_reset");
    reset   = 1'b0;
    exp_gen = 0;
    clear_model();
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || generation !== 32'd0) begin
      n_errors++;
      $display("FAIL solve_reset_pending: busy=%b generation=%0d, expected 0 0", busy, generation);
    end
  endtask

  task automatic test_reset_mid_edit();
    int w0;
    w0 = wr_count;
    @(negedge clk);
    edit_req = 1'b1; edit_row = 10'd4; edit_col = 10'd1; edit_op = 2'b01;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    edit_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (edit_ack !== 1'b0 || arena_write !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL edit_reset: ack=%b write=%b busy=%b, expected 0 0 0", edit_ack, arena_write, busy);
    end
    reset = 1'b0;
    clear_model();
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_count != w0) begin
      n_errors++;
      $display("FAIL edit_reset_write: %0d writes issued, expected 0", wr_count - w0);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; edit_req = 1'b0;
    edit_row = '0; edit_col = '0; edit_op = '0;
    clear_model();
    fork
      monitor();
    join_none
    test_reset();
    test_step();
    test_edit();
    test_back_to_back();
    test_out_of_range();
    test_edit_vs_step();
    test_drop();
    test_run();
    test_reset_mid_solve();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
